// File: rtl/weight_arb_rsp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : weight_arb_rsp_pkg
//  Description : Shared definitions for the weight read responder: FSM state
//                encoding, default geometry and the credit-counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package weight_arb_rsp_pkg;

    localparam int DEF_AW         = 32;
    localparam int DEF_DW         = 32;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Credits range over 0..depth inclusive, hence depth+1 codes.
    function automatic int credit_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int CREDIT_W = credit_w(DEF_FIFO_DEPTH);

endpackage
`default_nettype wire

// File: rtl/weight_arb_rsp_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rsp_fifo
//  Description : Synchronous FIFO holding {addr, data} response entries.
//                Head entry is presented combinationally; it reads as zero
//                while the FIFO is empty so the outputs are clean after reset.
//  Ports       : clk, rst_n       - clock, synchronous active-low reset
//                push, din        - write side
//                pop, dout        - read side (dout = head entry)
//                full, empty      - status
//                count            - current occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module rsp_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             din,
    input  logic                         pop,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PW-1:0]    PTR_LAST = PW'(DEPTH - 1);
    localparam logic [PW-1:0]    PTR_ONE  = PW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr, rd;

    assign full  = (count_q == CNT_MAX);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = empty ? '0 : mem_q[rptr_q];

    // A push against a full FIFO is still accepted when a pop frees the slot
    // in the same cycle, so nothing is ever silently dropped.
    assign wr = push & (~full | pop);
    assign rd = pop & ~empty;

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wr) begin
            mem_d[wptr_q] = din;
            wptr_d        = (wptr_q == PTR_LAST) ? '0 : wptr_q + PTR_ONE;
        end
        if (rd) begin
            rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + PTR_ONE;
        end
        case ({wr, rd})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible through valid pointers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // The upstream credit limit makes this unreachable.
    a_no_push_when_full : assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full));

endmodule
`default_nettype wire

// File: rtl/weight_arb_rsp.sv
`default_nettype none
// ============================================================================
//  Module      : weight_arb_rsp
//  Description : Weight-memory read responder. Accepts word read requests
//                from a bus owner, issues single-cycle SRAM reads and returns
//                {addr, data} responses in order through a credit-limited FIFO.
//  Ports       : clk, rst_n                    - clock, sync active-low reset
//                req_req/req_vld/req_addr/req_rdy - request side
//                rsp_addr/rsp_data/rsp_vld/rsp_rdy - response side
//                mem_ren/mem_raddr/mem_rdata   - SRAM read port (1-cycle)
//                busy, err_misalign            - status
//  Revision    : 1.0 - initial release
// ============================================================================
module weight_arb_rsp
    import weight_arb_rsp_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_req,
    input  logic          req_vld,
    input  logic [AW-1:0] req_addr,
    output logic          req_rdy,
    output logic [AW-1:0] rsp_addr,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_vld,
    input  logic          rsp_rdy,
    output logic          mem_ren,
    output logic [AW-3:0] mem_raddr,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          err_misalign
);

    localparam int CW = credit_w(FIFO_DEPTH);
    localparam logic [CW-1:0] C_MAX = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] C_ONE = CW'(1);

    state_e          state_q, state_d;
    logic [CW-1:0]   credits_q, credits_d;
    logic            inflight_q, inflight_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            err_q, err_d;

    logic            acc;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic [AW+DW-1:0] fifo_dout;

    // Credits cover both queued entries and the read still in the SRAM, so a
    // request is only taken when its response is guaranteed a FIFO slot.
    // Held low during reset so no read is launched that reset would discard.
    assign req_rdy = rst_n & req_req & (state_q != ST_DRAIN) & (credits_q < C_MAX);
    assign acc     = req_req & req_vld & req_rdy;
    assign pop     = rsp_vld & rsp_rdy;

    assign mem_ren   = acc;
    assign mem_raddr = req_addr[AW-1:2];

    assign rsp_vld              = ~fifo_empty;
    assign {rsp_addr, rsp_data} = fifo_dout;

    assign busy         = (state_q != ST_IDLE);
    assign err_misalign = err_q;

    rsp_fifo #(
        .WIDTH (AW + DW),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight_q),
        .din   ({addr_q, mem_rdata}),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (req_req) state_d = ST_GRANT;
            ST_GRANT: if (!req_req) state_d = (credits_q != '0) ? ST_DRAIN : ST_IDLE;
            ST_DRAIN: if (credits_q == '0) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        credits_d  = credits_q;
        inflight_d = acc;
        addr_d     = acc ? req_addr : addr_q;
        err_d      = err_q | (acc & (req_addr[1:0] != 2'b00));
        case ({acc, pop})
            2'b10:   credits_d = credits_q + C_ONE;
            2'b01:   credits_d = credits_q - C_ONE;
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            credits_q  <= '0;
            inflight_q <= 1'b0;
            addr_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            credits_q  <= credits_d;
            inflight_q <= inflight_d;
            addr_q     <= addr_d;
            err_q      <= err_d;
        end
    end

    a_credit_sum : assert property (@(posedge clk) disable iff (!rst_n)
        credits_q == fifo_count + CW'(inflight_q));
    a_full_means_max : assert property (@(posedge clk) disable iff (!rst_n)
        !fifo_full || (credits_q == C_MAX));

endmodule
`default_nettype wire

// File: tb/tb_weight_arb_rsp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_weight_arb_rsp
//  Description : Directed self-checking bench for weight_arb_rsp with an SRAM
//                model, a response scoreboard and a reference FSM/credit model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_weight_arb_rsp;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_req;
    logic          req_vld;
    logic [AW-1:0] req_addr;
    logic          req_rdy;
    logic [AW-1:0] rsp_addr;
    logic [DW-1:0] rsp_data;
    logic          rsp_vld;
    logic          rsp_rdy;
    logic          mem_ren;
    logic [AW-3:0] mem_raddr;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic          err_misalign;

    always #5 clk = ~clk;

    weight_arb_rsp #(.FIFO_DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_req      (req_req),
        .req_vld      (req_vld),
        .req_addr     (req_addr),
        .req_rdy      (req_rdy),
        .rsp_addr     (rsp_addr),
        .rsp_data     (rsp_data),
        .rsp_vld      (rsp_vld),
        .rsp_rdy      (rsp_rdy),
        .mem_ren      (mem_ren),
        .mem_raddr    (mem_raddr),
        .mem_rdata    (mem_rdata),
        .busy         (busy),
        .err_misalign (err_misalign)
    );

    function automatic logic [31:0] memf(input logic [29:0] w);
        return ({2'b00, w} * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    // SRAM: data valid exactly one cycle after the read enable.
    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= memf(mem_raddr);
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        int          vis;
    } exp_t;

    exp_t sb[$];

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   m_cred;
    int   m_state;              // 0 idle, 1 grant, 2 drain
    logic m_err;
    logic last_acc;
    int   acc_cnt = 0;
    int   pop_cnt = 0;
    int   first_acc_cyc, first_vld_cyc, last_vld_cyc, vld_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs are set by the caller at the falling edge.
    task automatic step();
        logic exp_rdy, acc, pop, exp_vld;
        int   ns;
        #1;
        exp_rdy = req_req && (m_state != 2) && (m_cred < DEPTH);
        if (rst_n) chk("req_rdy", req_rdy, exp_rdy);
        acc = rst_n && req_req && req_vld && exp_rdy;
        chk("mem_ren", mem_ren, acc);
        if (acc) begin
            chk("mem_raddr", mem_raddr, req_addr[31:2]);
            sb.push_back('{req_addr, memf(req_addr[31:2]), cyc + 2});
            acc_cnt++;
        end
        if (mem_ren === 1'b1 && first_acc_cyc < 0) first_acc_cyc = cyc;
        if (rsp_vld === 1'b1) begin
            if (first_vld_cyc < 0) first_vld_cyc = cyc;
            last_vld_cyc = cyc;
            vld_cnt++;
        end
        chk("busy", busy, m_state != 0);
        chk("err_misalign", err_misalign, m_err);
        exp_vld = (sb.size() > 0) && (sb[0].vis <= cyc);
        chk("rsp_vld", rsp_vld, exp_vld);
        if (exp_vld) begin
            chk("rsp_addr", rsp_addr, sb[0].a);
            chk("rsp_data", rsp_data, sb[0].d);
        end
        pop = rst_n && exp_vld && rsp_rdy;
        @(posedge clk);
        if (!rst_n) begin
            sb.delete();
            m_cred  = 0;
            m_state = 0;
            m_err   = 1'b0;
        end else begin
            if (pop) begin
                void'(sb.pop_front());
                pop_cnt++;
            end
            ns = m_state;
            case (m_state)
                0: if (req_req) ns = 1;
                1: if (!req_req) ns = (m_cred != 0) ? 2 : 0;
                2: if (m_cred == 0) ns = 0;
                default: ns = 0;
            endcase
            m_state = ns;
            m_cred  = m_cred + int'(acc) - int'(pop);
            if (acc && req_addr[1:0] != 2'b00) m_err = 1'b1;
        end
        last_acc = acc;
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain_and_release();
        int g;
        req_vld = 1'b0;
        rsp_rdy = 1'b1;
        g = 0;
        while (sb.size() != 0 && g < 50) begin
            step();
            g++;
        end
        chk("drain_empty", sb.size(), 0);
        req_req = 1'b0;
        step();
        step();
        chk("idle_busy", busy, 1'b0);
    endtask

    task automatic run_burst(input logic [31:0] base, input int n);
        int i, g, p0;
        first_acc_cyc = -1;
        first_vld_cyc = -1;
        last_vld_cyc  = -1;
        vld_cnt       = 0;
        p0            = pop_cnt;
        req_req = 1'b1;
        req_vld = 1'b1;
        rsp_rdy = 1'b1;
        i = 0;
        g = 0;
        while (i < n && g < n + 20) begin
            req_addr = base + 32'(4 * i);
            step();
            if (last_acc) i++;
            g++;
        end
        chk("burst_accs", i, n);
        drain_and_release();
        chk("burst_pops", pop_cnt - p0, n);
        chk("burst_latency", first_vld_cyc - first_acc_cyc, 2);
        chk("burst_vld_cycles", vld_cnt, n);
        chk("burst_no_bubble", last_vld_cyc - first_vld_cyc, n - 1);
    endtask

    // Keep requesting until the given number of accepts, bounded.
    task automatic accept_n(input int n, inout logic [31:0] addr);
        int a0, g;
        a0 = acc_cnt;
        g  = 0;
        while (acc_cnt - a0 < n && g < 20) begin
            req_addr = addr;
            step();
            if (last_acc) addr = addr + 32'd4;
            g++;
        end
        chk("accept_n", acc_cnt - a0, n);
    endtask

    initial begin
        logic [31:0] addr;
        int a0, p0;
        rst_n    = 1'b0;
        req_req  = 1'b0;
        req_vld  = 1'b0;
        req_addr = '0;
        rsp_rdy  = 1'b0;
        m_cred   = 0;
        m_state  = 0;
        m_err    = 1'b0;
        last_acc = 1'b0;
        first_acc_cyc = -1;
        first_vld_cyc = -1;
        last_vld_cyc  = -1;
        vld_cnt       = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_rsp_vld", rsp_vld, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err_misalign, 1'b0);
        chk("rst_rsp_addr", rsp_addr, 32'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_mem_ren", mem_ren, 1'b0);
        rst_n = 1'b1;
        step();

        // Full-rate burst of 144 words
        run_burst(32'h0000_1000, 144);

        // Backpressure: 10 stalled cycles admit exactly FIFO_DEPTH requests
        addr    = 32'h0000_4000;
        req_req = 1'b1;
        req_vld = 1'b1;
        rsp_rdy = 1'b0;
        a0 = acc_cnt;
        for (int k = 0; k < 10; k++) begin
            req_addr = addr;
            step();
            if (last_acc) addr = addr + 32'd4;
        end
        chk("bp_accs", acc_cnt - a0, DEPTH);
        chk("bp_rdy_low", req_rdy, 1'b0);
        rsp_rdy = 1'b1;
        p0 = pop_cnt;
        for (int k = 0; k < 12; k++) begin
            req_addr = addr;
            step();
            if (last_acc) addr = addr + 32'd4;
        end
        chk("bp_resume_pops", pop_cnt - p0 >= DEPTH, 1'b1);
        drain_and_release();

        // Full credits with rsp_rdy toggling 1,0,1,0...
        addr    = 32'h0000_5000;
        req_req = 1'b1;
        req_vld = 1'b1;
        rsp_rdy = 1'b0;
        accept_n(DEPTH, addr);
        a0 = acc_cnt;
        p0 = pop_cnt;
        for (int k = 0; k < 16; k++) begin
            rsp_rdy  = (k % 2 == 0);
            req_addr = addr;
            step();
            if (last_acc) addr = addr + 32'd4;
        end
        chk("tog_accs", acc_cnt - a0, 8);
        chk("tog_pops", pop_cnt - p0, 8);
        drain_and_release();

        // Drain: release with 3 outstanding, re-request while draining
        addr    = 32'h0000_6000;
        req_req = 1'b1;
        req_vld = 1'b1;
        rsp_rdy = 1'b0;
        accept_n(3, addr);
        req_req = 1'b0;
        req_vld = 1'b0;
        step();
        chk("drain_busy", busy, 1'b1);
        req_req = 1'b1;
        req_vld = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_addr = addr;
            step();
            chk("drain_rdy", req_rdy, 1'b0);
        end
        req_req = 1'b0;
        req_vld = 1'b0;
        rsp_rdy = 1'b1;
        p0 = pop_cnt;
        for (int g = 0; g < 10 && busy !== 1'b0; g++) step();
        chk("drain_pops", pop_cnt - p0, 3);
        chk("drain_idle", busy, 1'b0);

        // Misaligned access: sticky flag, data of the containing word
        addr    = 32'h0000_2002;
        req_req = 1'b1;
        req_vld = 1'b1;
        rsp_rdy = 1'b1;
        accept_n(1, addr);
        req_vld = 1'b0;
        step();
        step();
        chk("misalign_err", err_misalign, 1'b1);
        addr    = 32'h0000_2008;
        req_vld = 1'b1;
        accept_n(1, addr);
        drain_and_release();
        chk("misalign_sticky", err_misalign, 1'b1);

        // Mid-burst reset with two entries queued
        addr    = 32'h0000_7000;
        req_req = 1'b1;
        req_vld = 1'b1;
        rsp_rdy = 1'b0;
        accept_n(2, addr);
        req_vld = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n   = 1'b1;
        req_req = 1'b0;
        chk("mrst_rsp_vld", rsp_vld, 1'b0);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_err", err_misalign, 1'b0);
        chk("mrst_rsp_addr", rsp_addr, 32'h0);
        chk("mrst_rsp_data", rsp_data, 32'h0);
        rsp_rdy = 1'b1;
        repeat (4) step();
        run_burst(32'h0000_1000, 144);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/weight_arb_rsp.md
WEIGHT_ARB_RSP -- requirements
Module: weight_arb_rsp

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, response FIFO entries and maximum outstanding reads.
REQ-002 Parameter AW, default 32, address width; DW, default 32, data width.
REQ-003 clk  input  1  clock; all logic on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req_req  input  1  requester holds bus ownership for a burst.
REQ-006 req_vld  input  1  request address valid.
REQ-007 req_addr  input  AW  byte address of a 32-bit word.
REQ-008 req_rdy  output  1  responder can accept a request this cycle.
REQ-009 rsp_addr  output  AW  address belonging to rsp_data.
REQ-010 rsp_data  output  DW  read data.
REQ-011 rsp_vld  output  1  response valid.
REQ-012 rsp_rdy  input  1  requester accepts the response.
REQ-013 mem_ren  output  1  SRAM read enable; mem_raddr  output  AW-2  word address; mem_rdata  input  DW  read data, valid exactly 1 cycle after mem_ren.
REQ-014 busy  output  1  state is not IDLE; err_misalign  output  1  sticky flag, accepted address had addr[1:0] != 0.

Function
REQ-015 Request accept (acc) SHALL be req_req & req_vld & req_rdy; each acc SHALL produce exactly one response, in acceptance order.
REQ-016 req_rdy SHALL be combinational: req_req & (state != DRAIN) & (credits < FIFO_DEPTH), where credits = FIFO occupancy + in-flight reads.
REQ-017 On acc: mem_ren=1 and mem_raddr=req_addr[AW-1:2] in the same cycle; req_addr SHALL be registered alongside an in-flight bit.
REQ-018 One cycle after acc, {registered addr, mem_rdata} SHALL be pushed into the FIFO.
REQ-019 rsp_vld SHALL equal FIFO non-empty; rsp_addr/rsp_data SHALL be the FIFO head; pop on rsp_vld & rsp_rdy.
REQ-020 Latency: with the FIFO empty and rsp_rdy=1, rsp_vld SHALL rise 2 cycles after acc (acc in cycle N, push at the end of N+1, rsp_vld in N+2).
REQ-021 Throughput: with rsp_rdy held at 1, SHALL sustain 1 acc and 1 response per cycle indefinitely.
REQ-022 Credit counter: +1 on acc, -1 on pop, unchanged on simultaneous acc and pop; never exceeds FIFO_DEPTH; never underflows.
REQ-023 FIFO full and push, which cannot occur because of the credit limit, SHALL be flagged by an assertion; no data is dropped.
REQ-024 FSM states: IDLE, GRANT, DRAIN.
REQ-025 IDLE->GRANT when req_req=1.
REQ-026 GRANT->DRAIN when req_req falls and credits != 0.
REQ-027 GRANT->IDLE when req_req falls and credits == 0.
REQ-028 DRAIN->IDLE when credits == 0; DRAIN->GRANT is not allowed, and req_rdy=0 in DRAIN.
REQ-029 An acc in the same cycle that req_req would fall cannot occur, because acc requires req_req=1.
REQ-030 err_misalign SHALL set on acc with req_addr[1:0] != 0 and clear only on reset; the read still proceeds with the low bits dropped.
REQ-031 Response data SHALL be held stable while rsp_vld=1 and rsp_rdy=0.

Reset
REQ-032 On rst_n=0 at a clock edge, all of the following SHALL be 0: FIFO pointers, credits, in-flight bit, state (IDLE), rsp_vld, mem_ren, busy and err_misalign.
REQ-033 On that reset edge, rsp_addr and rsp_data SHALL also be 0.
REQ-034 Reset mid-burst SHALL discard all outstanding and queued responses; no response may appear after reset until a new acc.

Structure
REQ-035 Shared package SHALL hold the FSM state encoding, the default AW/DW/FIFO_DEPTH and the credit-counter width ($clog2(FIFO_DEPTH+1)).
REQ-036 One sub-module, rsp_fifo (synchronous, parameterised width/depth, full/empty/count), SHALL hold {addr, data}.
REQ-037 Control and the FSM SHALL reside in weight_arb_rsp.

Verification
REQ-038 Burst at full rate: req_req=1, vld=1, 0x1000..0x123C (144 words), rsp_rdy=1 -> 144 in-order responses, rsp_addr matches, first rsp_vld 2 cycles after the first acc, no bubbles.
REQ-039 Backpressure: rsp_rdy=0 for 10 cycles with vld=1 -> exactly 4 accs, then req_rdy=0; after rsp_rdy=1, 4 pops and streaming resume with no loss or duplicates.
REQ-040 Simultaneous acc and pop with credits=4 and rsp_rdy toggling 1010 -> credits bounded to 3..4; all data matches the memory model.
REQ-041 Drain: req_req drops with 3 outstanding -> DRAIN, req_rdy=0, 3 responses, then IDLE and busy=0.
REQ-042 Misalign: acc with addr 0x2002 -> err_misalign=1 permanently, and the response carries the data of word 0x2000.
REQ-043 Mid-burst reset: rst_n=0 for 1 cycle with 2 queued -> rsp_vld=0 after the edge, credits=0, IDLE; the next burst behaves as in REQ-038.
